// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one overlapping "1101" detector across NUM_CH
// serial lanes, with per-lane saved detector state and saturating match counters.
module seq_detect_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] bit_valid,
  input  logic [NUM_CH-1:0] bit_in,
  output logic [NUM_CH-1:0] bit_ready,
  input  logic [NUM_CH-1:0] ch_flush,
  input  logic              clr_cnt,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [2:0]        st [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic [NUM_CH-1:0] elig;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_idx;
  logic [2:0]        nxt_st;
  logic              hit;

  function automatic logic [2:0] step(input logic [2:0] s, input logic b);
    case (s)
      S0:      step = b ? S1 : S0;
      S1:      step = b ? S2 : S0;
      S2:      step = b ? S2 : S3;
      S3:      step = b ? S4 : S0;
      S4:      step = b ? S2 : S0;
      default: step = S0;
    endcase
  endfunction

  // Flushing lanes are masked so their pending bit stays unconsumed.
  assign elig = bit_valid & ~ch_flush & {NUM_CH{en & ~rst}};

  always_comb begin
    logic [CH_W-1:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    bit_ready = '0;
    if (gnt_any) bit_ready[gnt_idx] = 1'b1;
  end

  assign nxt_st = step(st[gnt_idx], bit_in[gnt_idx]);
  assign hit    = gnt_any && (nxt_st == S4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) st[k] <= S0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_flush[k]) st[k] <= S0;
        else if (gnt_any && gnt_idx == CH_W'(k)) st[k] <= nxt_st;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gnt_idx;
    end
  end

  // A clear in the same cycle as a match wins; the match pulse is still issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else if (clr_cnt) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit && gnt_idx == CH_W'(k) && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NUM_CH) cnt_out = cnt[cnt_sel];
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Table-driven bench for seq_detect_sched with a scoreboard of expected match
// pulses and counter reads, plus hand-written reset and enable sequences.
module tb_seq_detect_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NUM_CH-1:0] bit_valid;
  logic [NUM_CH-1:0] bit_in;
  logic [NUM_CH-1:0] bit_ready;
  logic [NUM_CH-1:0] ch_flush;
  logic              clr_cnt;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CH_W-1:0]   cnt_sel;
  logic [CNT_W-1:0]  cnt_out;

  seq_detect_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .ch_flush(ch_flush), .clr_cnt(clr_cnt),
    .match_valid(match_valid), .match_ch(match_ch), .cnt_sel(cnt_sel),
    .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] bits;
    logic [3:0] flush;
    logic       clr;
    logic [1:0] sel;
    logic [3:0] exp_ready;
    logic       exp_mv;
    logic [1:0] exp_ch;
    logic [1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic       mv;
    logic [1:0] ch;
    logic [1:0] cnt;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tagBase = 0;

  task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic addVec(input logic e, input logic [3:0] v, input logic [3:0] b,
                        input logic [3:0] f, input logic c, input logic [1:0] s,
                        input logic [3:0] r, input logic mv, input logic [1:0] ch,
                        input logic [1:0] cn);
    vec_t x;
    x.en = e; x.valid = v; x.bits = b; x.flush = f; x.clr = c; x.sel = s;
    x.exp_ready = r; x.exp_mv = mv; x.exp_ch = ch; x.exp_cnt = cn;
    vecs.push_back(x);
  endtask

  task automatic idleInputs();
    en = 1'b1; bit_valid = '0; bit_in = '0; ch_flush = '0; clr_cnt = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal($sformatf("match_valid[%0d]", e.tag), match_valid, e.mv);
    if (e.mv) compareVal($sformatf("match_ch[%0d]", e.tag), match_ch, e.ch);
    compareVal($sformatf("cnt_out[%0d]", e.tag), cnt_out, e.cnt);
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
    en = v.en; bit_valid = v.valid; bit_in = v.bits; ch_flush = v.flush;
    clr_cnt = v.clr; cnt_sel = v.sel;
    #2;
    compareVal($sformatf("bit_ready[%0d]", tag), bit_ready, v.exp_ready);
    e.mv = v.exp_mv; e.ch = v.exp_ch; e.cnt = v.exp_cnt; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], tagBase + i);
    tagBase += 100;
    @(posedge clk); #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
    idleInputs();
    vecs.delete();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    idleInputs();
    bit_valid = 4'hF;
    cnt_sel = '0;
    #2;
    compareVal("reset_ready", bit_ready, 4'h0);
    compareVal("reset_mv", match_valid, 1'b0);
    compareVal("reset_ch", match_ch, 2'd0);
    compareVal("reset_cnt", cnt_out, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bit_valid = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    cnt_sel = '0;
    idleInputs();
    resetDut();

    // Lone lane 0: 1101101 matches after the 4th and 7th bits.
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 1, 2'd0, 2'd1);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd1);
    addVec(1, 4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd1);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 1, 2'd0, 2'd2);
    runTable();

    // All lanes valid: grants rotate 0..3; lanes 0 and 2 see 1101, 1 and 3 see zeros.
    resetDut();
    for (int c = 0; c < 16; c++) begin
      logic [3:0] b;
      logic [3:0] r;
      b = (c / 4 == 2) ? 4'b0000 : 4'b0101;
      r = 4'b0001 << (c % 4);
      addVec(1, 4'b1111, b, 4'b0000, 0, 2'd2, r, (c == 12) || (c == 14),
             (c == 12) ? 2'd0 : 2'd2, (c >= 14) ? 2'd1 : 2'd0);
    end
    runTable();

    // Lane 1: 110, flush (masked), then 1 alone does not match, 1101 afterwards does.
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0000, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0010, 0, 2'd1, 4'b0000, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0000, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 1, 2'd1, 2'd1);
    runTable();

    // Lane 3: six overlapping matches, counter saturates at 3; clear wins on the sixth.
    begin
      int nm;
      nm = 0;
      for (int i = 0; i < 19; i++) begin
        logic bv;
        logic mv;
        logic [1:0] ce;
        bv = (i < 4) ? (i != 2) : ((i - 4) % 3 != 1);
        mv = (i >= 3) && ((i - 3) % 3 == 0);
        if (mv) nm++;
        ce = (i == 18) ? 2'd0 : ((nm > 3) ? 2'd3 : 2'(nm));
        addVec(1, 4'b1000, bv ? 4'b1000 : 4'b0000, 4'b0000, (i == 18), 2'd3,
               4'b1000, mv, 2'd3, ce);
      end
    end
    runTable();

    // Enable low for five cycles: no grants, pointer and lane state held.
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++)
      addVec(0, 4'b1111, 4'b0000, 4'b0000, 0, 2'd1, 4'b0000, 0, 2'd0, 2'd0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 2'd1, 4'b0100, 0, 2'd0, 2'd0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 2'd1, 4'b1000, 0, 2'd0, 2'd0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 2'd1, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
    addVec(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1, 4'b0010, 1, 2'd1, 2'd1);
    runTable();

    // Lane 0: reset lands between the 3rd and 4th bit of 1101.
    resetDut();
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    runTable();
    bit_valid = 4'b0001; bit_in = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    compareVal("midrst_ready", bit_ready, 4'b0000);
    compareVal("midrst_mv", match_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idleInputs();
    @(posedge clk); #1;
    compareVal("midrst_nomatch", match_valid, 1'b0);

    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 0, 2'd0, 2'd0);
    addVec(1, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 4'b0001, 1, 2'd0, 2'd1);
    runTable();

    // Reset while a match pulse is showing clears it immediately.
    bit_valid = 4'b0001; bit_in = 4'b0001;
    @(posedge clk); #1;
    bit_in = 4'b0000;
    @(posedge clk); #1;
    bit_in = 4'b0001;
    @(posedge clk); #1;
    compareVal("async_pre_mv", match_valid, 1'b1);
    compareVal("async_pre_cnt", cnt_out, 2'd2);
    rst = 1'b1;
    #1;
    compareVal("async_mv", match_valid, 1'b0);
    compareVal("async_cnt", cnt_out, 2'd0);
    compareVal("async_ready", bit_ready, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    idleInputs();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
